sb_multi: RTL and testbench

- Parametrised successor to the single-entry scoreboard. Tracks pending destination registers for up to NUM_FU concurrently busy function units.
- Issues one instruction per cycle when its target FU is free and its sources are either clean or being written back this cycle.
- Sits between decode/register-read and the FU issue ports. Forwards FU writeback data into the source operands with byte-enable merge.

---
 rtl/sb_pkg.sv | 30 +++
 rtl/sb_fwd_mux.sv | 60 ++++++
 rtl/sb_multi.sv | 172 +++++++++++++++++
 tb/tb_sb_multi.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// Shared constants and helpers for the multi-FU scoreboard.
// FU indices, HI/LO/HILO register aliases and the byte-merge helper.
package sb_pkg;

  localparam int FU_ALU = 0;
  localparam int FU_BRU = 1;
  localparam int FU_LSU = 2;
  localparam int FU_MDU = 3;

  localparam int HI_IDX        = 32;
  localparam int LO_IDX        = 33;
  localparam int HILO_IDX_DFLT = 34;

  // Helper works on the widest supported operand; callers cast in and out.
  localparam int MAX_DW = 256;
  localparam int MAX_BW = MAX_DW / 8;

  function automatic logic [MAX_DW-1:0] merge_bytes(
    input logic [MAX_DW-1:0] new_v,
    input logic [MAX_DW-1:0] old_v,
    input logic [MAX_BW-1:0] wen
  );
    logic [MAX_DW-1:0] res;
    for (int b = 0; b < MAX_BW; b++) begin
      res[8*b +: 8] = wen[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sb_fwd_mux.sv
// Per-source bypass-hit detect and byte-merged operand forwarding.
// Forwarding is only built when SB_BYPASS_EN is defined.
module sb_fwd_mux
  import sb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REGBIT     = 6,
  parameter int NUM_FU     = 4,
  parameter int FUW        = 2
) (
  input  logic [REGBIT-1:0]              src_i,
  input  logic [DATA_WIDTH-1:0]          src_value_i,
  input  logic                           pend_i,
  input  logic [FUW-1:0]                 prod_i,
  input  logic [NUM_FU-1:0]              wb_valid_i,
  input  logic [NUM_FU*REGBIT-1:0]       wb_dst_i,
  input  logic [NUM_FU*DATA_WIDTH-1:0]   wb_data_i,
  input  logic [NUM_FU*DATA_WIDTH/8-1:0] wb_byte_wen_i,
  output logic                           hit_o,
  output logic [DATA_WIDTH-1:0]          value_o
);

  localparam int BW = DATA_WIDTH / 8;

  logic [REGBIT-1:0] dst_a [NUM_FU];

  always_comb begin
    for (int f = 0; f < NUM_FU; f++) begin
      dst_a[f] = wb_dst_i[f*REGBIT +: REGBIT];
    end
  end

  // Only the producing FU may satisfy a pending source.
  assign hit_o = pend_i && (src_i != '0) &&
                 wb_valid_i[prod_i] &&
                 (dst_a[prod_i] == src_i);

`ifdef SB_BYPASS_EN
  logic [DATA_WIDTH-1:0] data_a [NUM_FU];
  logic [BW-1:0]         wen_a  [NUM_FU];

  always_comb begin
    for (int f = 0; f < NUM_FU; f++) begin
      data_a[f] = wb_data_i[f*DATA_WIDTH +: DATA_WIDTH];
      wen_a[f]  = wb_byte_wen_i[f*BW +: BW];
    end
  end

  assign value_o = hit_o
    ? DATA_WIDTH'(merge_bytes(MAX_DW'(data_a[prod_i]),
                              MAX_DW'(src_value_i),
                              MAX_BW'(wen_a[prod_i])))
    : src_value_i;
`else
  logic unused_wb;
  assign unused_wb = ^{wb_data_i, wb_byte_wen_i};
  assign value_o   = src_value_i;
`endif

endmodule

// File: rtl/sb_multi.sv
// Multi-FU scoreboard: pending-dst tracking, issue gating, operand forward.
// Optional SB_BYPASS_EN lets same-cycle writebacks satisfy sources.
module sb_multi
  import sb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 40,
  parameter int REGBIT     = 6,
  parameter int NUM_FU     = 4,
  parameter int HILO_IDX   = HILO_IDX_DFLT
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             valid,
  input  logic [REGBIT-1:0]                dst,
  input  logic [REGBIT-1:0]                src1,
  input  logic [REGBIT-1:0]                src2,
  input  logic [DATA_WIDTH-1:0]            src1_value,
  input  logic [DATA_WIDTH-1:0]            src2_value,
  input  logic [NUM_FU-1:0]                issue_fu,
  input  logic [NUM_FU-1:0]                fu_ready,
  input  logic [NUM_FU-1:0]                wb_valid,
  input  logic [NUM_FU*REGBIT-1:0]         wb_dst,
  input  logic [NUM_FU*DATA_WIDTH-1:0]     wb_data,
  input  logic [NUM_FU*DATA_WIDTH/8-1:0]   wb_byte_wen,
  output logic                             inst_run,
  output logic [DATA_WIDTH-1:0]            real_src1_value,
  output logic [DATA_WIDTH-1:0]            real_src2_value,
  output logic [$clog2(NUM_REGS+1)-1:0]    pending_cnt
);

  localparam int FUW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int NR  = 1 << REGBIT;
  localparam int CW  = $clog2(NUM_REGS + 1);

  localparam logic [REGBIT-1:0] HI_R   = REGBIT'(HI_IDX);
  localparam logic [REGBIT-1:0] LO_R   = REGBIT'(LO_IDX);
  localparam logic [REGBIT-1:0] HILO_R = REGBIT'(HILO_IDX);

  logic [NR-1:0]     pend_q, pend_d;
  logic [FUW-1:0]    prod_q [NR];
  logic [FUW-1:0]    prod_d [NR];
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [REGBIT-1:0] wb_dst_a [NUM_FU];
  logic [FUW-1:0]    fu_idx;
  logic              fu_ok;
  logic              hit1, hit2;
  logic              ok1, ok2;
  logic              hilo_free;
  logic              free1, free2;

  always_comb begin
    for (int f = 0; f < NUM_FU; f++) begin
      wb_dst_a[f] = wb_dst[f*REGBIT +: REGBIT];
    end
  end

  always_comb begin
    fu_idx = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      if (issue_fu[f]) fu_idx = FUW'(f);
    end
  end

  assign fu_ok = (issue_fu == '0) || ((issue_fu & fu_ready) != '0);

  sb_fwd_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .REGBIT     (REGBIT),
    .NUM_FU     (NUM_FU),
    .FUW        (FUW)
  ) u_fwd1 (
    .src_i         (src1),
    .src_value_i   (src1_value),
    .pend_i        (pend_q[src1]),
    .prod_i        (prod_q[src1]),
    .wb_valid_i    (wb_valid),
    .wb_dst_i      (wb_dst),
    .wb_data_i     (wb_data),
    .wb_byte_wen_i (wb_byte_wen),
    .hit_o         (hit1),
    .value_o       (real_src1_value)
  );

  sb_fwd_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .REGBIT     (REGBIT),
    .NUM_FU     (NUM_FU),
    .FUW        (FUW)
  ) u_fwd2 (
    .src_i         (src2),
    .src_value_i   (src2_value),
    .pend_i        (pend_q[src2]),
    .prod_i        (prod_q[src2]),
    .wb_valid_i    (wb_valid),
    .wb_dst_i      (wb_dst),
    .wb_data_i     (wb_data),
    .wb_byte_wen_i (wb_byte_wen),
    .hit_o         (hit2),
    .value_o       (real_src2_value)
  );

`ifdef SB_BYPASS_EN
  logic hilo_hit;

  assign hilo_hit  = pend_q[HILO_R] &&
                     wb_valid[prod_q[HILO_R]] &&
                     (wb_dst_a[prod_q[HILO_R]] == HILO_R);
  assign hilo_free = !pend_q[HILO_R] || hilo_hit;
  assign ok1       = !pend_q[src1] || hit1;
  assign ok2       = !pend_q[src2] || hit2;
`else
  logic unused_hit;

  assign unused_hit = hit1 ^ hit2;
  assign hilo_free  = !pend_q[HILO_R];
  assign ok1        = !pend_q[src1];
  assign ok2        = !pend_q[src2];
`endif

  // HI and LO reads also wait on the combined HILO destination.
  assign free1 = (src1 == '0) ||
                 (ok1 && (!((src1 == HI_R) || (src1 == LO_R)) || hilo_free));
  assign free2 = (src2 == '0) ||
                 (ok2 && (!((src2 == HI_R) || (src2 == LO_R)) || hilo_free));

  assign inst_run = valid && free1 && free2 && fu_ok && !flush;

  always_comb begin
    pend_d = pend_q;
    prod_d = prod_q;
    if (flush) begin
      pend_d = '0;
    end else begin
      // Stale writebacks (WAW-superseded producer) leave pend untouched.
      for (int f = 0; f < NUM_FU; f++) begin
        if (wb_valid[f] && (prod_q[wb_dst_a[f]] == FUW'(f))) begin
          pend_d[wb_dst_a[f]] = 1'b0;
        end
      end
      if (inst_run && (dst != '0) && (int'(dst) < NUM_REGS)) begin
        pend_d[dst] = 1'b1;
        prod_d[dst] = fu_idx;
      end
    end
  end

  always_comb begin
    cnt_d = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      cnt_d = cnt_d + CW'(pend_d[r]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      cnt_q  <= '0;
      for (int r = 0; r < NR; r++) begin
        prod_q[r] <= '0;
      end
    end else begin
      pend_q <= pend_d;
      prod_q <= prod_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pending_cnt = cnt_q;

endmodule

// File: tb/tb_sb_multi.sv
// Scoreboard bench for sb_multi: driver queues expectations per cycle,
// a negedge monitor pops and compares the combinational outputs.
module tb_sb_multi;

`ifdef SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [3:0] ALU = 4'b0001;
  localparam logic [3:0] BRU = 4'b0010;
  localparam logic [3:0] LSU = 4'b0100;
  localparam logic [3:0] MDU = 4'b1000;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         valid;
  logic [5:0]   dst, src1, src2;
  logic [31:0]  src1_value, src2_value;
  logic [3:0]   issue_fu, fu_ready, wb_valid;
  logic [23:0]  wb_dst;
  logic [127:0] wb_data;
  logic [15:0]  wb_byte_wen;
  logic         inst_run;
  logic [31:0]  real_src1_value, real_src2_value;
  logic [5:0]   pending_cnt;

  sb_multi dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .valid           (valid),
    .dst             (dst),
    .src1            (src1),
    .src2            (src2),
    .src1_value      (src1_value),
    .src2_value      (src2_value),
    .issue_fu        (issue_fu),
    .fu_ready        (fu_ready),
    .wb_valid        (wb_valid),
    .wb_dst          (wb_dst),
    .wb_data         (wb_data),
    .wb_byte_wen     (wb_byte_wen),
    .inst_run        (inst_run),
    .real_src1_value (real_src1_value),
    .real_src2_value (real_src2_value),
    .pending_cnt     (pending_cnt)
  );

  typedef struct {
    string        name;
    logic         flush, valid;
    logic [5:0]   dst, s1, s2;
    logic [31:0]  v1, v2;
    logic [3:0]   ifu, rdy, wbv;
    logic [23:0]  wbd;
    logic [127:0] wdat;
    logic [15:0]  wen;
    logic         er;
    logic [5:0]   ec;
    logic         cv;
    logic [31:0]  e1, e2;
  } vec_t;

  vec_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string n, string what,
                     logic [31:0] got, logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s %s: got 0x%0h required 0x%0h",
                  n, what, got, exp);
  endtask

  function automatic vec_t nv(string n);
    vec_t v;
    v.name  = n;
    v.flush = 1'b0;
    v.valid = 1'b0;
    v.dst   = '0;
    v.s1    = '0;
    v.s2    = '0;
    v.v1    = 32'h0101_0101;
    v.v2    = 32'h0202_0202;
    v.ifu   = '0;
    v.rdy   = 4'hF;
    v.wbv   = '0;
    v.wbd   = '0;
    v.wdat  = '0;
    v.wen   = '0;
    v.er    = 1'b0;
    v.ec    = '0;
    v.cv    = 1'b1;
    v.e1    = 32'h0101_0101;
    v.e2    = 32'h0202_0202;
    return v;
  endfunction

  task automatic go(input vec_t v);
    @(posedge clk);
    #1;
    flush       = v.flush;
    valid       = v.valid;
    dst         = v.dst;
    src1        = v.s1;
    src2        = v.s2;
    src1_value  = v.v1;
    src2_value  = v.v2;
    issue_fu    = v.ifu;
    fu_ready    = v.rdy;
    wb_valid    = v.wbv;
    wb_dst      = v.wbd;
    wb_data     = v.wdat;
    wb_byte_wen = v.wen;
    q.push_back(v);
  endtask

  always @(negedge clk) begin
    vec_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk(e.name, "inst_run", 32'(inst_run), 32'(e.er));
      chk(e.name, "pending_cnt", 32'(pending_cnt), 32'(e.ec));
      if (e.cv) begin
        chk(e.name, "real_src1", real_src1_value, e.e1);
        chk(e.name, "real_src2", real_src2_value, e.e2);
      end
    end
  end

  initial begin
    vec_t v;
    rst = 1'b1; flush = 1'b0; valid = 1'b0;
    dst = '0; src1 = '0; src2 = '0;
    src1_value = '0; src2_value = '0;
    issue_fu = '0; fu_ready = 4'hF; wb_valid = '0;
    wb_dst = '0; wb_data = '0; wb_byte_wen = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    v = nv("reset"); go(v);

    v = nv("iss5"); v.valid = 1; v.dst = 5; v.ifu = ALU; v.er = 1; go(v);

    v = nv("stall5"); v.valid = 1; v.s1 = 5; v.ifu = BRU; v.ec = 1; go(v);

    v = nv("byp5"); v.valid = 1; v.s1 = 5; v.ifu = BRU;
    v.wbv = ALU; v.wbd[5:0] = 6'd5; v.wdat[31:0] = 32'h1234_5678;
    v.wen[3:0] = 4'hF; v.ec = 1; v.er = BYP;
    v.e1 = BYP ? 32'h1234_5678 : 32'h0101_0101; go(v);

    v = nv("late5"); v.valid = 1; v.s1 = 5; v.ifu = BRU; v.er = 1; go(v);

    v = nv("iss6"); v.valid = 1; v.dst = 6; v.ifu = ALU; v.er = 1; go(v);

    v = nv("part6"); v.valid = 1; v.s1 = 6; v.s2 = 6;
    v.v1 = 32'h1111_2222; v.v2 = 32'h3333_4444;
    v.wbv = ALU; v.wbd[5:0] = 6'd6; v.wdat[31:0] = 32'hAAAA_BBBB;
    v.wen[3:0] = 4'b0011; v.ec = 1; v.er = BYP;
    v.e1 = BYP ? 32'h1111_BBBB : 32'h1111_2222;
    v.e2 = BYP ? 32'h3333_BBBB : 32'h3333_4444; go(v);

    v = nv("part6b"); v.valid = 1; v.s1 = 6; v.s2 = 6;
    v.v1 = 32'h1111_2222; v.v2 = 32'h3333_4444; v.er = 1;
    v.e1 = 32'h1111_2222; v.e2 = 32'h3333_4444; go(v);

    v = nv("waw_alu"); v.valid = 1; v.dst = 7; v.ifu = ALU; v.er = 1; go(v);

    v = nv("waw_lsu"); v.valid = 1; v.dst = 7; v.ifu = LSU;
    v.er = 1; v.ec = 1; go(v);

    v = nv("waw_stale"); v.valid = 1; v.s1 = 7;
    v.wbv = ALU; v.wbd[5:0] = 6'd7; v.wdat[31:0] = 32'hDEAD_BEEF;
    v.wen[3:0] = 4'hF; v.ec = 1; go(v);

    v = nv("waw_held"); v.valid = 1; v.s1 = 7; v.ec = 1; go(v);

    v = nv("waw_lsu_wb"); v.valid = 1; v.s1 = 7;
    v.wbv = LSU; v.wbd[17:12] = 6'd7; v.wdat[95:64] = 32'hCAFE_F00D;
    v.wen[11:8] = 4'hF; v.ec = 1; v.er = BYP;
    v.e1 = BYP ? 32'hCAFE_F00D : 32'h0101_0101; go(v);

    v = nv("waw_clear"); v.valid = 1; v.s1 = 7; v.er = 1; go(v);

    v = nv("mdu_hilo"); v.valid = 1; v.dst = 34; v.ifu = MDU;
    v.er = 1; go(v);

    v = nv("hi_stall"); v.valid = 1; v.s1 = 32; v.ifu = ALU;
    v.ec = 1; go(v);

    v = nv("hi_wb"); v.valid = 1; v.s1 = 32; v.ifu = ALU;
    v.wbv = MDU; v.wbd[23:18] = 6'd34; v.wdat[127:96] = 32'h5566_7788;
    v.wen[15:12] = 4'hF; v.ec = 1; v.er = BYP; go(v);

    v = nv("hi_go"); v.valid = 1; v.s1 = 32; v.s2 = 33; v.ifu = ALU;
    v.er = 1; go(v);

    v = nv("p1"); v.valid = 1; v.dst = 8; v.ifu = ALU; v.er = 1; go(v);
    v = nv("p2"); v.valid = 1; v.dst = 9; v.ifu = LSU;
    v.er = 1; v.ec = 1; go(v);
    v = nv("p3"); v.valid = 1; v.dst = 10; v.ifu = MDU;
    v.er = 1; v.ec = 2; go(v);

    v = nv("flush"); v.flush = 1; v.valid = 1; v.dst = 11; v.ifu = ALU;
    v.ec = 3; go(v);

    v = nv("flushed"); go(v);

    v = nv("lsu_busy"); v.valid = 1; v.dst = 12; v.ifu = LSU;
    v.rdy = 4'b1011; go(v);

    v = nv("lsu_after"); go(v);

    v = nv("same1"); v.valid = 1; v.dst = 13; v.ifu = ALU; v.er = 1; go(v);

    v = nv("same2"); v.valid = 1; v.dst = 13; v.ifu = ALU;
    v.wbv = ALU; v.wbd[5:0] = 6'd13; v.er = 1; v.ec = 1; go(v);

    v = nv("same_held"); v.ec = 1; go(v);

    v = nv("same_wb"); v.wbv = ALU; v.wbd[5:0] = 6'd13; v.ec = 1; go(v);

    v = nv("dst0"); v.valid = 1; v.ifu = ALU; v.er = 1; go(v);

    v = nv("end"); go(v);

    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
